// File: rtl/serial_word_tx.sv
// Serial word transmitter: start bit (0), WIDTH data bits MSB first, stop bit (1).
// Each bit is held for CLKS_PER_BIT cycles. All outputs are registered.
module serial_word_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic             out_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_end;

    always_comb begin
        shift_d = shift_q << 1;
        bit_end = (cnt_q == CNT_LAST);
    end

    // NOTE: the reset branch is asynchronous so the line returns to idle (1)
    // the instant reset falls, without waiting for a clock edge.
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    if (load && ready_q) begin
                        shift_q <= data_in;
                        state_q <= START;
                        out_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                    if (bit_end) begin
                        state_q <= DATA;
                        out_q   <= shift_q[WIDTH-1];
                    end
                end
                DATA: begin
                    cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                            out_q   <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            // The next bit to send is the MSB of the shifted word.
                            shift_q <= shift_d;
                            out_q   <= shift_d[WIDTH-1];
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                    if (bit_end) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (8 bits x 4 clks, 4 bits x 1 clk) compared
// each cycle against a frame-timing model, plus directed frame scenarios.
module tb_serial_word_tx;

    localparam int WA = 8, CA = 4, FRAME_A = (WA + 2) * CA;
    localparam int WB = 4, CB = 1, FRAME_B = (WB + 2) * CB;

    logic       clk;
    logic       reset;
    logic [7:0] data_a;
    logic       load_a, ready_a, out_a, busy_a, done_a;
    logic [3:0] data_b;
    logic       load_b, ready_b, out_b, busy_b, done_b;

    int n_tests = 0;
    int n_fail  = 0;

    serial_word_tx #(.WIDTH(WA), .CLKS_PER_BIT(CA)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_a), .load(load_a),
        .ready(ready_a), .out(out_a), .busy(busy_a), .done(done_a)
    );

    serial_word_tx #(.WIDTH(WB), .CLKS_PER_BIT(CB)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_b), .load(load_b),
        .ready(ready_b), .out(out_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Line level at cycle t (0-based) of a frame: start, MSB-first data, stop.
    function automatic logic frame_out(input logic [31:0] word, input int t,
                                       input int w, input int cpb);
        int p;
        p = t / cpb;
        if (p == 0) return 1'b0;
        if (p <= w) return word[w - p];
        return 1'b1;
    endfunction

    logic        ma_act, ma_done, mb_act, mb_done;
    int          ma_t, mb_t;
    logic [31:0] ma_word, mb_word;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma_act <= 1'b0; ma_done <= 1'b0; ma_t <= 0; ma_word <= '0;
        end else if (ma_act) begin
            ma_t <= ma_t + 1;
            ma_done <= (ma_t == FRAME_A - 1);
            if (ma_t == FRAME_A - 1) ma_act <= 1'b0;
        end else begin
            ma_done <= 1'b0;
            if (load_a) begin
                ma_act <= 1'b1; ma_t <= 0; ma_word <= 32'(data_a);
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mb_act <= 1'b0; mb_done <= 1'b0; mb_t <= 0; mb_word <= '0;
        end else if (mb_act) begin
            mb_t <= mb_t + 1;
            mb_done <= (mb_t == FRAME_B - 1);
            if (mb_t == FRAME_B - 1) mb_act <= 1'b0;
        end else begin
            mb_done <= 1'b0;
            if (load_b) begin
                mb_act <= 1'b1; mb_t <= 0; mb_word <= 32'(data_b);
            end
        end
    end

    always @(negedge clk) begin
        check("a_out",   out_a,   ma_act ? frame_out(ma_word, ma_t, WA, CA) : 1'b1);
        check("a_busy",  busy_a,  ma_act);
        check("a_ready", ready_a, !ma_act);
        check("a_done",  done_a,  ma_done);
        check("b_out",   out_b,   mb_act ? frame_out(mb_word, mb_t, WB, CB) : 1'b1);
        check("b_busy",  busy_b,  mb_act);
        check("b_ready", ready_b, !mb_act);
        check("b_done",  done_b,  mb_done);
    end

    task automatic wait_done_a(input string tag, input int budget);
        int n;
        n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, done_a, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [5:0] seq_b;
        reset = 1'b0; load_a = 1'b0; load_b = 1'b0; data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_out", out_a, 1'b1);
        check("rst_ready", ready_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        reset = 1'b1;

        // 0xA5 frame, with an ignored 0x3C load and a data_in change mid-frame.
        @(negedge clk);
        pat = 8'hA5; data_a = pat; load_a = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            logic e;
            @(negedge clk);
            if (c == 1) load_a = 1'b0;
            if (c == 10) begin load_a = 1'b1; data_a = 8'h3C; end
            if (c == 11) begin load_a = 1'b0; data_a = 8'h00; end
            if (c <= 4)       e = 1'b0;
            else if (c <= 36) e = pat[7 - (c - 5) / 4];
            else              e = 1'b1;
            check("a5_out", out_a, e);
            check("a5_done", done_a, c == 41);
            check("a5_ready", ready_a, c >= 41);
        end

        // 0xFF with load held through done; 0x00 follows back-to-back.
        data_a = 8'hFF; load_a = 1'b1;
        @(negedge clk);
        wait_done_a("ff", 60);
        data_a = 8'h00;
        @(negedge clk);
        check("b2b_busy", busy_a, 1'b1);
        check("b2b_out", out_a, 1'b0);
        load_a = 1'b0;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 32; c++) begin
            check("zero_bits", out_a, 1'b0);
            @(negedge clk);
        end
        wait_done_a("zero", 20);

        // Reset between edges in cycle 20 aborts the frame.
        @(negedge clk);
        data_a = 8'h5A; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_out", out_a, 1'b1);
        check("abort_busy", busy_a, 1'b0);
        check("abort_ready", ready_a, 1'b1);
        check("abort_done", done_a, 1'b0);
        data_a = 8'h81; load_a = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy_a, 1'b1);
        load_a = 1'b0;
        wait_done_a("x81", 60);

        // 4-bit word 0x9 at one clock per bit.
        @(negedge clk);
        data_b = 4'h9; load_b = 1'b1;
        seq_b = 6'b010011;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) load_b = 1'b0;
            check("b9_out", out_b, (c <= 6) ? seq_b[6 - c] : 1'b1);
            check("b9_done", done_b, c == 7);
        end

        // Random traffic on both instances, with occasional mid-cycle resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load_a = ($urandom_range(0, 3) == 0);
            data_a = 8'($urandom);
            load_b = ($urandom_range(0, 2) == 0);
            data_b = 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #3 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end
        load_a = 1'b0; load_b = 1'b0;
        repeat (50) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
